// File: rtl/record_playback_ctrl_pkg.sv
// Shared definitions for the record/playback controller: parameter defaults
// and the controller state encoding.
package record_playback_ctrl_pkg;

    localparam int unsigned FIFO_DEPTH_DEF = 16;
    localparam int unsigned ADDR_W_DEF     = 26;
    localparam int unsigned SAMPLE_W       = 8;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_REC       = 3'd1;
    localparam state_t S_REC_WR    = 3'd2;
    localparam state_t S_PLAY_WAIT = 3'd3;
    localparam state_t S_PLAY_REQ  = 3'd4;
    localparam state_t S_PLAY_ACK  = 3'd5;

endpackage

// File: rtl/record_playback_ctrl_sample_fifo.sv
// Capture FIFO between the ADC sample stream and the RAM write path.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module sample_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra bit on each index distinguishes full from empty.
    logic [AW:0]      wr_idx;
    logic [AW:0]      rd_idx;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_idx == rd_idx);
    assign full    = (wr_idx[AW] != rd_idx[AW]) && (wr_idx[AW-1:0] == rd_idx[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_idx[AW-1:0]];

    // Index update: clear empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx <= '0;
            rd_idx <= '0;
        end else if (clear) begin
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            if (do_push) wr_idx <= wr_idx + (AW+1)'(1);
            if (do_pop)  rd_idx <= rd_idx + (AW+1)'(1);
        end
    end

    // Sample storage, no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx[AW-1:0]] <= din;
    end

endmodule

// File: rtl/record_playback_ctrl.sv
// Record/playback controller: buffers ADC samples through a small FIFO into
// RAM via a wrapper handshake, and replays them paced by sample_tick.
module record_playback_ctrl
    import record_playback_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic [7:0]        sample_in,
    input  logic              sample_valid,
    input  logic              sample_tick,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        data_in,
    output logic              write_enable,
    output logic              read_request,
    output logic              read_ack,
    input  logic [7:0]        data_out,
    input  logic              rdy,
    input  logic              rd_data_pres,
    input  logic [ADDR_W-1:0] max_ram_address,
    output logic [7:0]        sample_out,
    output logic              sample_out_valid,
    output logic              busy,
    output logic              overflow
);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    // One bit wider than an address so a full RAM length is representable.
    logic [ADDR_W:0]   rec_len;
    logic              stop_pend;
    // Set once the read pointer has consumed max_ram_address.
    logic              rd_last;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_clear;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_head;

    // FIFO control: capture while recording, pop when a RAM write is issued.
    always_comb begin
        fifo_push  = sample_valid && ((state == S_REC) || (state == S_REC_WR));
        fifo_pop   = (state == S_REC) && !fifo_empty && rdy;
        fifo_clear = (state == S_IDLE) && rec_start;
    end

    assign busy = (state != S_IDLE);

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (sample_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Controller FSM with registered wrapper-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            rec_len          <= '0;
            stop_pend        <= 1'b0;
            rd_last          <= 1'b0;
            address          <= '0;
            data_in          <= '0;
            write_enable     <= 1'b0;
            read_request     <= 1'b0;
            read_ack         <= 1'b0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            write_enable     <= 1'b0;
            read_ack         <= 1'b0;
            sample_out_valid <= 1'b0;
            // A stop that lands mid-write or mid-handshake is honoured later.
            if (stop && (state != S_IDLE)) stop_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    stop_pend <= 1'b0;
                    if (rec_start) begin
                        state    <= S_REC;
                        wr_ptr   <= '0;
                        overflow <= 1'b0;
                    end else if (play_start) begin
                        state   <= S_PLAY_WAIT;
                        rd_ptr  <= '0;
                        rd_last <= 1'b0;
                    end
                end
                S_REC: begin
                    if (!fifo_empty && rdy) begin
                        state        <= S_REC_WR;
                        address      <= wr_ptr;
                        data_in      <= fifo_head;
                        write_enable <= 1'b1;
                    end else if (fifo_empty && (stop || stop_pend)) begin
                        state   <= S_IDLE;
                        rec_len <= {1'b0, wr_ptr};
                    end
                end
                S_REC_WR: begin
                    if (wr_ptr == max_ram_address) begin
                        state   <= S_IDLE;
                        rec_len <= {1'b0, wr_ptr} + (ADDR_W+1)'(1);
                    end else begin
                        state  <= S_REC;
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                    end
                end
                S_PLAY_WAIT: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (sample_tick) begin
                        if (!rd_last && ({1'b0, rd_ptr} < rec_len)) begin
                            state        <= S_PLAY_REQ;
                            address      <= rd_ptr;
                            read_request <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_PLAY_REQ: begin
                    if (rd_data_pres) begin
                        state            <= S_PLAY_ACK;
                        sample_out       <= data_out;
                        sample_out_valid <= 1'b1;
                        read_request     <= 1'b0;
                        read_ack         <= 1'b1;
                    end
                end
                S_PLAY_ACK: begin
                    if (rd_ptr == max_ram_address) rd_last <= 1'b1;
                    else                           rd_ptr  <= rd_ptr + ADDR_W'(1);
                    state <= (stop || stop_pend) ? S_IDLE : S_PLAY_WAIT;
                end
                default: state <= S_IDLE;
            endcase

            if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_record_playback_ctrl.sv
// Self-checking bench for record_playback_ctrl. The bench plays the RAM
// wrapper role and compares against a queue/array model of record and replay.
module tb_record_playback_ctrl;

    localparam int AW = 26;
    localparam int FD = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          rec_start = 1'b0;
    logic          play_start = 1'b0;
    logic          stop = 1'b0;
    logic [7:0]    sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_tick = 1'b0;
    logic [AW-1:0] address;
    logic [7:0]    data_in;
    logic          write_enable;
    logic          read_request;
    logic          read_ack;
    logic [7:0]    data_out = '0;
    logic          rdy = 1'b1;
    logic          rd_data_pres = 1'b0;
    logic [AW-1:0] max_ram_address = AW'(63);
    logic [7:0]    sample_out;
    logic          sample_out_valid;
    logic          busy;
    logic          overflow;

    record_playback_ctrl #(
        .FIFO_DEPTH (FD),
        .ADDR_W     (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rec_start        (rec_start),
        .play_start       (play_start),
        .stop             (stop),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .sample_tick      (sample_tick),
        .address          (address),
        .data_in          (data_in),
        .write_enable     (write_enable),
        .read_request     (read_request),
        .read_ack         (read_ack),
        .data_out         (data_out),
        .rdy              (rdy),
        .rd_data_pres     (rd_data_pres),
        .max_ram_address  (max_ram_address),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .busy             (busy),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]    ram [0:63];
    logic [AW-1:0] wr_addr_q[$];
    logic [7:0]    wr_data_q[$];
    logic [7:0]    out_q[$];
    logic [7:0]    stim_q[$];
    int            ack_cnt = 0;
    int            rr_cnt = 0;
    int            excl_cnt = 0;

    // Wrapper-side observer: logs writes into the RAM model, replayed samples,
    // acknowledges and any overlap of the three strobes.
    always @(negedge clk) begin
        if (write_enable) begin
            wr_addr_q.push_back(address);
            wr_data_q.push_back(data_in);
            ram[address[5:0]] = data_in;
        end
        if (sample_out_valid) out_q.push_back(sample_out);
        if (read_ack) ack_cnt++;
        if (read_request) rr_cnt++;
        if (int'(write_enable) + int'(read_request) + int'(read_ack) > 1) excl_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        out_q.delete();
        ack_cnt = 0;
        rr_cnt  = 0;
    endtask

    task automatic pulse_rec();
        rec_start = 1'b1;
        step(1);
        rec_start = 1'b0;
    endtask

    // Present every entry of stim_q with random idle gaps; optionally toggle rdy.
    task automatic feed(input bit rand_rdy, input int max_gap);
        int gap;
        foreach (stim_q[i]) begin
            gap = int'($urandom_range(max_gap, 0));
            repeat (gap) begin
                if (rand_rdy) rdy = 1'($urandom_range(1, 0));
                step(1);
            end
            sample_in    = stim_q[i];
            sample_valid = 1'b1;
            if (rand_rdy) rdy = 1'($urandom_range(1, 0));
            step(1);
            sample_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            step(1);
            c++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b required 0 within %0d cycles", name, busy, budget);
        end
    endtask

    task automatic stop_and_wait(input string name);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        wait_idle(name, 200);
    endtask

    // Writes must be stim_q[0..n-1] at consecutive addresses from 0.
    task automatic check_writes(input string name, input int n);
        checks++;
        if (wr_addr_q.size() !== n) begin
            errors++;
            $display("FAIL %s write count: got %0d required %0d", name, wr_addr_q.size(), n);
        end
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== stim_q[i]) begin
                errors++;
                $display("FAIL %s write %0d: got addr %0d data %02h required addr %0d data %02h",
                         name, i, wr_addr_q[i], wr_data_q[i], i, stim_q[i]);
            end
        end
    endtask

    task automatic check_len(input string name, input int n);
        checks++;
        if (dut.rec_len !== (AW+1)'(n)) begin
            errors++;
            $display("FAIL %s rec_len: got %0d required %0d", name, dut.rec_len, n);
        end
    endtask

    // Replay with random ticks; the wrapper answers each request after delay cycles.
    task automatic play(input string name, input int delay, input int n_exp);
        int waitc;
        int cyc;
        clear_logs();
        play_start = 1'b1;
        step(1);
        play_start = 1'b0;
        waitc = 0;
        cyc   = 0;
        while (busy && cyc < 2000) begin
            sample_tick = ($urandom_range(3, 0) == 0);
            if (rd_data_pres) begin
                rd_data_pres = 1'b0;
            end else if (read_request) begin
                waitc++;
                if (waitc >= delay) begin
                    rd_data_pres = 1'b1;
                    data_out     = ram[address[5:0]];
                    waitc        = 0;
                end
            end
            step(1);
            cyc++;
        end
        sample_tick  = 1'b0;
        rd_data_pres = 1'b0;
        step(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s playback end: busy=%b required 0", name, busy);
        end
        checks++;
        if (out_q.size() !== n_exp || ack_cnt !== n_exp) begin
            errors++;
            $display("FAIL %s playback count: got %0d samples %0d acks required %0d",
                     name, out_q.size(), ack_cnt, n_exp);
        end
        for (int i = 0; i < n_exp && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== stim_q[i]) begin
                errors++;
                $display("FAIL %s sample %0d: got %02h required %02h", name, i, out_q[i], stim_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(2);
        checks++;
        if ({address, data_in, write_enable, read_request, read_ack, sample_out,
             sample_out_valid, busy, overflow} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got addr %0h din %02h we %b rr %b ra %b so %02h sov %b busy %b ovf %b required all 0",
                     address, data_in, write_enable, read_request, read_ack, sample_out,
                     sample_out_valid, busy, overflow);
        end
        check_len("reset", 0);
        reset = 1'b1;
        step(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset release: busy=%b required 0", busy);
        end
    endtask

    task automatic test_empty_play();
        clear_logs();
        play_start = 1'b1;
        step(1);
        play_start = 1'b0;
        step(2);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL empty play wait: busy=%b required 1", busy);
        end
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(1);
        checks++;
        if (busy !== 1'b0 || rr_cnt !== 0) begin
            errors++;
            $display("FAIL empty play: busy=%b reads=%0d required busy 0 reads 0", busy, rr_cnt);
        end
    endtask

    task automatic test_record_basic();
        clear_logs();
        stim_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        rdy = 1'b1;
        pulse_rec();
        feed(1'b0, 2);
        step(4);
        stop_and_wait("record basic");
        check_writes("record basic", 5);
        check_len("record basic", 5);
    endtask

    task automatic test_stop_wait();
        clear_logs();
        play_start = 1'b1;
        step(1);
        play_start = 1'b0;
        step(2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        checks++;
        if (busy !== 1'b0 || out_q.size() !== 0) begin
            errors++;
            $display("FAIL stop in wait: busy=%b samples=%0d required 0 and 0", busy, out_q.size());
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        stim_q.delete();
        for (int i = 0; i < 20; i++) stim_q.push_back(8'($urandom));
        rdy = 1'b0;
        pulse_rec();
        feed(1'b0, 0);
        step(1);
        checks++;
        if (overflow !== 1'b1 || wr_addr_q.size() !== 0) begin
            errors++;
            $display("FAIL overflow flag: got ovf %b writes %0d required ovf 1 writes 0",
                     overflow, wr_addr_q.size());
        end
        rdy = 1'b1;
        for (int c = 0; c < 200 && wr_addr_q.size() < 16; c++) step(1);
        step(4);
        stop_and_wait("overflow");
        check_writes("overflow", 16);
        check_len("overflow", 16);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 3; it++) begin
            clear_logs();
            stim_q.delete();
            n = int'($urandom_range(16, 1));
            for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
            pulse_rec();
            if (it == 0) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL overflow clear on rec_start: got %b required 0", overflow);
                end
            end
            feed(1'b1, 3);
            rdy = 1'b1;
            stop_and_wait("random record");
            check_writes("random record", n);
            check_len("random record", n);
            play("random play", int'($urandom_range(5, 1)), n);
        end
    endtask

    task automatic test_max_addr();
        clear_logs();
        stim_q.delete();
        for (int i = 0; i < 10; i++) stim_q.push_back(8'($urandom));
        max_ram_address = AW'(3);
        rdy = 1'b1;
        pulse_rec();
        feed(1'b0, 2);
        step(4);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL max addr auto end: busy=%b required 0", busy);
        end
        check_writes("max addr", 4);
        check_len("max addr", 4);
        play("max addr play", 2, 4);
        max_ram_address = AW'(63);
    endtask

    task automatic test_both_start();
        clear_logs();
        rec_start  = 1'b1;
        play_start = 1'b1;
        step(1);
        rec_start  = 1'b0;
        play_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL both start busy: got %b required 1", busy);
        end
        stim_q = '{8'hA5};
        rdy = 1'b1;
        feed(1'b0, 0);
        step(3);
        checks++;
        if (rr_cnt !== 0) begin
            errors++;
            $display("FAIL both start read: got %0d read cycles required 0", rr_cnt);
        end
        stop_and_wait("both start");
        check_writes("both start", 1);
        check_len("both start", 1);
    endtask

    task automatic test_reset_mid();
        int c;
        clear_logs();
        play_start = 1'b1;
        step(1);
        play_start = 1'b0;
        sample_tick = 1'b1;
        c = 0;
        while (!read_request && c < 50) begin
            step(1);
            c++;
        end
        sample_tick = 1'b0;
        checks++;
        if (read_request !== 1'b1) begin
            errors++;
            $display("FAIL reset mid setup: read_request=%b required 1", read_request);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({address, data_in, write_enable, read_request, read_ack, sample_out,
             sample_out_valid, busy, overflow} !== '0) begin
            errors++;
            $display("FAIL reset mid outputs: got rr %b ra %b busy %b addr %0h so %02h required all 0",
                     read_request, read_ack, busy, address, sample_out);
        end
        check_len("reset mid", 0);
        step(1);
        reset = 1'b1;
        step(3);
        checks++;
        if (ack_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset mid ack: got acks %0d busy %b required 0 and 0", ack_cnt, busy);
        end
    endtask

    initial begin
        test_reset();
        test_empty_play();
        test_record_basic();
        play("basic play", 3, 5);
        test_stop_wait();
        test_overflow();
        test_random();
        test_max_addr();
        test_both_start();
        test_reset_mid();
        checks++;
        if (excl_cnt !== 0) begin
            errors++;
            $display("FAIL strobe exclusivity: got %0d overlapping cycles required 0", excl_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
